// File: rtl/mmio_port_ctrl_if.sv
// Processor-side data bus between the CPU and the MMIO port controller.
// Read data comes back one cycle after the address is presented.
interface mmio_port_ctrl_if #(
  parameter int N  = 8,
  parameter int AW = 8
);
  logic [AW-1:0] A;
  logic [N-1:0]  WD;
  logic          WE;
  logic [N-1:0]  RD;

  modport master (output A, WD, WE, input RD);
  modport slave  (input A, WD, WE, output RD);
endinterface

// File: rtl/mmio_port_ctrl.sv
// Memory-mapped I/O controller: 16-word I/O window at IO_BASE with input
// channels (change detect, pending, IRQ) and registered outputs; other addresses go to RAM.
module mmio_in_lane #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_e,
  input  logic         i_clr,
  output logic         o_pend,
  output logic         o_pend_nxt
);
  logic [N-1:0] r_last;
  logic         r_pend;
  logic         w_chg;

  assign w_chg      = (i_e != r_last);
  // A change on the same edge as a clear keeps the flag set so no event is lost.
  assign o_pend_nxt = w_chg | (r_pend & ~i_clr);
  assign o_pend     = r_pend;

  always_ff @(posedge clk) begin
    r_last <= i_e;
    if (rst) r_pend <= 1'b0;
    else     r_pend <= o_pend_nxt;
  end
endmodule

module mmio_port_ctrl #(
  parameter int N       = 8,
  parameter int AW      = 8,
  parameter int NIN     = 4,
  parameter int NOUT    = 4,
  parameter int IO_BASE = 2**AW - 16
) (
  input  logic              CLK,
  input  logic              RESET,
  mmio_port_ctrl_if.slave   bus,
  output logic              MEM_WE,
  input  logic [N-1:0]      MRD,
  input  logic [NIN*N-1:0]  E,
  output logic [NOUT*N-1:0] S,
  output logic              IRQ
);
  localparam int BASE_HI = IO_BASE / 16;

  logic                     w_io_hit;
  logic [3:0]               w_off;
  logic                     w_wr_io;
  logic                     w_rd_io;
  logic [NIN-1:0]           w_clr;
  logic [NIN-1:0]           w_pend;
  logic [NIN-1:0]           w_pend_nxt;
  logic [NIN-1:0]           w_ie_nxt;
  logic [N-1:0]             w_io_rdata;

  logic [NOUT-1:0][N-1:0]   r_s;
  logic [NIN-1:0]           r_ie;
  logic                     r_irq;
  logic                     r_io_sel;
  logic [N-1:0]             r_io_data;

  assign w_io_hit = (bus.A[AW-1:4] == (AW-4)'(BASE_HI));
  assign w_off    = bus.A[3:0];
  assign w_wr_io  = w_io_hit & bus.WE;
  assign w_rd_io  = w_io_hit & ~bus.WE;
  assign MEM_WE   = bus.WE & ~w_io_hit;

  genvar gi;
  for (gi = 0; gi < NIN; gi++) begin : g_in
    // Reading IN[i] acknowledges it; so does writing 1 to its PEND bit.
    assign w_clr[gi] = (w_rd_io & (w_off == 4'(gi)))
                     | (w_wr_io & (w_off == 4'd14) & bus.WD[gi]);
    mmio_in_lane #(.N(N)) u_lane (
      .clk        (CLK),
      .rst        (RESET),
      .i_e        (E[gi*N +: N]),
      .i_clr      (w_clr[gi]),
      .o_pend     (w_pend[gi]),
      .o_pend_nxt (w_pend_nxt[gi])
    );
  end

  assign w_ie_nxt = (w_wr_io && w_off == 4'd15) ? bus.WD[NIN-1:0] : r_ie;

  always_comb begin
    w_io_rdata = '0;
    for (int i = 0; i < NIN; i++)
      if (w_off == 4'(i)) w_io_rdata = E[i*N +: N];
    for (int j = 0; j < NOUT; j++)
      if (w_off == 4'(NIN + j)) w_io_rdata = r_s[j];
    if (w_off == 4'd14) w_io_rdata[NIN-1:0] = w_pend;
    if (w_off == 4'd15) w_io_rdata[NIN-1:0] = r_ie;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_s       <= '0;
      r_ie      <= '0;
      r_irq     <= 1'b0;
      r_io_sel  <= 1'b0;
      r_io_data <= '0;
    end else begin
      for (int j = 0; j < NOUT; j++)
        if (w_wr_io && w_off == 4'(NIN + j)) r_s[j] <= bus.WD;
      r_ie      <= w_ie_nxt;
      r_irq     <= |(w_pend_nxt & w_ie_nxt);
      r_io_sel  <= w_io_hit;
      r_io_data <= w_io_rdata;
    end
  end

  assign bus.RD = r_io_sel ? r_io_data : MRD;
  assign S      = r_s;
  assign IRQ    = r_irq;
endmodule

// File: tb/tb_mmio_port_ctrl.sv
// Directed bench for mmio_port_ctrl: reset, OUT write/read, change detect/IRQ,
// set-vs-clear race, RAM pass-through and ignored writes.
module tb_mmio_port_ctrl;
  logic            CLK = 1'b0;
  logic            RESET;
  logic            MEM_WE;
  logic [7:0]      MRD;
  logic [3:0][7:0] e_ch;
  logic [31:0]     E;
  logic [31:0]     S;
  logic            IRQ;
  logic [7:0]      mem [256];
  int              n_chk = 0;
  int              n_fail = 0;

  mmio_port_ctrl_if #(.N(8), .AW(8)) bus ();

  assign E = e_ch;

  mmio_port_ctrl #(.N(8), .AW(8), .NIN(4), .NOUT(4), .IO_BASE(240)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .bus    (bus),
    .MEM_WE (MEM_WE),
    .MRD    (MRD),
    .E      (E),
    .S      (S),
    .IRQ    (IRQ)
  );

  always #5 CLK = ~CLK;

  // Synchronous RAM with one-cycle read latency.
  always @(posedge CLK) begin
    if (MEM_WE) mem[bus.A] <= bus.WD;
    MRD <= mem[bus.A];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] wd, input logic we);
    bus.A  = a;
    bus.WD = wd;
    bus.WE = we;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    e_ch  = {8'h44, 8'h33, 8'h22, 8'h11};
    RESET = 1'b1;
    drive(8'hFE, 8'h00, 1'b0);
    repeat (3) tick();
    chk("rst_S", S, 32'h0);
    chk("rst_IRQ", {31'b0, IRQ}, 32'h0);
    RESET = 1'b0;
    tick();
    chk("rst_PEND", {24'b0, bus.RD}, 32'h00);

    // OUT[0] write then read back
    drive(8'hF4, 8'hA5, 1'b1);
    chk("out_wr_MEM_WE", {31'b0, MEM_WE}, 32'h0);
    tick();
    chk("out_S0", {24'b0, S[7:0]}, 32'hA5);
    drive(8'hF4, 8'h00, 1'b0);
    chk("out_rd_MEM_WE", {31'b0, MEM_WE}, 32'h0);
    tick();
    chk("out_RD", {24'b0, bus.RD}, 32'hA5);
    drive(8'hF5, 8'h3C, 1'b1);
    tick();
    chk("out_S1", S, 32'h00003CA5);

    // IE, change on channel 1, interrupt, acknowledge by reading IN[1]
    drive(8'hFF, 8'h02, 1'b1);
    tick();
    chk("ie_IRQ_quiet", {31'b0, IRQ}, 32'h0);
    drive(8'h00, 8'h00, 1'b0);
    e_ch[1] = 8'h99;
    tick();
    chk("chg_IRQ", {31'b0, IRQ}, 32'h1);
    drive(8'hFE, 8'h00, 1'b0);
    tick();
    chk("chg_PEND", {24'b0, bus.RD}, 32'h02);
    drive(8'hF1, 8'h00, 1'b0);
    tick();
    chk("in_RD", {24'b0, bus.RD}, 32'h99);
    chk("ack_IRQ", {31'b0, IRQ}, 32'h0);
    drive(8'hFE, 8'h00, 1'b0);
    tick();
    chk("ack_PEND", {24'b0, bus.RD}, 32'h00);

    // Change again on the same edge as a W1C of that bit: set wins
    e_ch[1] = 8'h55;
    tick();
    chk("race_IRQ_set", {31'b0, IRQ}, 32'h1);
    drive(8'hFE, 8'h02, 1'b1);
    e_ch[1] = 8'h66;
    tick();
    chk("race_IRQ", {31'b0, IRQ}, 32'h1);
    drive(8'hFE, 8'h00, 1'b0);
    tick();
    chk("race_PEND", {24'b0, bus.RD}, 32'h02);
    drive(8'hFE, 8'h0F, 1'b1);
    tick();
    chk("w1c_IRQ", {31'b0, IRQ}, 32'h0);
    drive(8'hFE, 8'h00, 1'b0);
    tick();
    chk("w1c_PEND", {24'b0, bus.RD}, 32'h00);

    // RAM pass-through
    drive(8'h10, 8'h5A, 1'b1);
    chk("ram_MEM_WE", {31'b0, MEM_WE}, 32'h1);
    tick();
    drive(8'h10, 8'h00, 1'b0);
    chk("ram_rd_MEM_WE", {31'b0, MEM_WE}, 32'h0);
    tick();
    chk("ram_RD", {24'b0, bus.RD}, 32'h5A);

    // Writes to IN and unmapped offsets change nothing
    drive(8'hF0, 8'hFF, 1'b1);
    chk("in_wr_MEM_WE", {31'b0, MEM_WE}, 32'h0);
    tick();
    drive(8'hFC, 8'hFF, 1'b1);
    chk("unm_wr_MEM_WE", {31'b0, MEM_WE}, 32'h0);
    tick();
    chk("unm_S", S, 32'h00003CA5);
    drive(8'hFC, 8'h00, 1'b0);
    tick();
    chk("unm_RD", {24'b0, bus.RD}, 32'h00);
    drive(8'hF0, 8'h00, 1'b0);
    tick();
    chk("in0_RD", {24'b0, bus.RD}, 32'h11);
    drive(8'hFF, 8'h00, 1'b0);
    tick();
    chk("ie_RD", {24'b0, bus.RD}, 32'h02);
    chk("end_IRQ", {31'b0, IRQ}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
